obstacle_tile_renderer: RTL and testbench

- Parametrised, pipelined successor to the obstacle pixel colouring path.
- Per pixel, it selects one of STYLE_NUM wall styles from the obstacle's absolute position using a hash or a pseudo-random rule, mirrors the tile by face, and fetches the style texel from an external texture ROM.
- It resolves the texel through a runtime-writable palette and emits registered RGB with a valid flag.
- Adds frame-driven style animation and palette reload. It sits between the obstacle position generator and the VGA pixel mux.

---
 rtl/obstacle_tile_renderer.sv | 145 ++++++++++++++
 tb/tb_obstacle_tile_renderer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_tile_renderer.sv
// obstacle_tile_renderer: per-pixel wall-style selection, face mirroring, texture ROM
// addressing and palette lookup, in a 3-stage pipeline with frame-driven style animation.
`default_nettype none

module obstacle_tile_renderer #(
  parameter int OBSTACLE_WIDTH = 10,
  parameter int Y_SHIFT        = 1,
  parameter int SCREEN_WIDTH   = 10,
  parameter int PHY_WIDTH      = 15,
  parameter int PIXEL_WIDTH    = 12,
  parameter int STYLE_NUM      = 4,
  parameter int STYLE_WIDTH    = $clog2(STYLE_NUM),
  parameter int COLOR_NUM      = 4,
  parameter int CID_WIDTH      = $clog2(COLOR_NUM),
  parameter int ANIM_EN        = 1,
  parameter int ANIM_PERIOD    = 30
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    pix_valid,
  input  logic                    obstacle_on,
  input  logic [SCREEN_WIDTH-1:0] obstacle_x_rom,
  input  logic [SCREEN_WIDTH-1:0] obstacle_y_rom,
  input  logic [PHY_WIDTH-1:0]    obstacle_block_abs_y,
  input  logic [PHY_WIDTH-1:0]    obstacle_abs_pos_x,
  input  logic [PHY_WIDTH-1:0]    obstacle_abs_pos_y,
  input  logic                    frame_tick,
  output logic [STYLE_WIDTH-1:0]  tex_style,
  output logic [SCREEN_WIDTH-1:0] tex_x,
  output logic [SCREEN_WIDTH-1:0] tex_y,
  input  logic [CID_WIDTH-1:0]    tex_cid,
  input  logic                    pal_wr_valid,
  output logic                    pal_wr_ready,
  input  logic [CID_WIDTH-1:0]    pal_wr_addr,
  input  logic [PIXEL_WIDTH-1:0]  pal_wr_data,
  output logic                    rgb_valid,
  output logic                    rgb_on,
  output logic [PIXEL_WIDTH-1:0]  rgb
);

  localparam int SLICES = (PHY_WIDTH + STYLE_WIDTH - 1) / STYLE_WIDTH;
  localparam int PAD_W  = SLICES * STYLE_WIDTH;
  localparam int FC_W   = $clog2(ANIM_PERIOD + 1);

  logic [SCREEN_WIDTH-1:0] which, xm;
  logic [PHY_WIDTH-1:0]    block_x;
  logic [PAD_W-1:0]        ay_pad;
  logic [STYLE_WIDTH-1:0]  hash, base;
  logic [STYLE_WIDTH:0]    hash_ext;
  logic                    rnd, face;

  logic [STYLE_WIDTH-1:0]  tex_style_d, tex_style_q;
  logic [SCREEN_WIDTH-1:0] tex_x_d, tex_x_q, tex_y_d, tex_y_q;
  logic                    s1_valid_q, s1_on_q, s2_valid_q, s2_on_q;
  logic [CID_WIDTH-1:0]    s2_cid_q;
  logic                    rgb_valid_q, rgb_on_q;
  logic [PIXEL_WIDTH-1:0]  rgb_q;
  logic [PIXEL_WIDTH-1:0]  pal_q [COLOR_NUM];
  logic [FC_W-1:0]         frame_cnt_q;
  logic [STYLE_WIDTH-1:0]  anim_offset_q;

  function automatic logic [PIXEL_WIDTH-1:0] pal_rst(input int idx);
    case (idx)
      0:       pal_rst = PIXEL_WIDTH'(12'hAAA);
      1:       pal_rst = PIXEL_WIDTH'(12'h777);
      3:       pal_rst = PIXEL_WIDTH'(12'h5B0);
      default: pal_rst = '0;
    endcase
  endfunction

  // A trailing partial slice of the absolute y is zero-padded before folding.
  assign ay_pad = PAD_W'(obstacle_abs_pos_y);
  always_comb begin
    hash = '0;
    for (int i = 0; i < SLICES; i++) hash = hash ^ ay_pad[i*STYLE_WIDTH +: STYLE_WIDTH];
  end

  assign which    = obstacle_x_rom / SCREEN_WIDTH'(OBSTACLE_WIDTH);
  assign xm       = obstacle_x_rom % SCREEN_WIDTH'(OBSTACLE_WIDTH);
  assign block_x  = (obstacle_abs_pos_x << 2) + obstacle_block_abs_y
                  + PHY_WIDTH'(which) * PHY_WIDTH'(OBSTACLE_WIDTH);
  assign rnd      = block_x[4] & block_x[3] & (|block_x[1:0]);
  assign base     = rnd ? block_x[STYLE_WIDTH-1:0] : hash;
  assign hash_ext = {1'b0, hash};
  assign face     = rnd | (hash_ext[1] ^ hash_ext[0]);

  assign tex_style_d = base + anim_offset_q;
  assign tex_x_d     = face ? xm : SCREEN_WIDTH'(OBSTACLE_WIDTH - 1) - xm;
  assign tex_y_d     = obstacle_y_rom >> Y_SHIFT;

  assign pal_wr_ready = ~(pix_valid | s1_valid_q | s2_valid_q | rgb_valid_q);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tex_style_q   <= '0;
      tex_x_q       <= '0;
      tex_y_q       <= '0;
      s1_valid_q    <= 1'b0;
      s1_on_q       <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_on_q       <= 1'b0;
      s2_cid_q      <= '0;
      rgb_valid_q   <= 1'b0;
      rgb_on_q      <= 1'b0;
      rgb_q         <= '0;
      frame_cnt_q   <= '0;
      anim_offset_q <= '0;
      for (int i = 0; i < COLOR_NUM; i++) pal_q[i] <= pal_rst(i);
    end else begin
      s1_valid_q <= pix_valid;
      s1_on_q    <= pix_valid & obstacle_on;
      if (pix_valid) begin
        tex_style_q <= tex_style_d;
        tex_x_q     <= tex_x_d;
        tex_y_q     <= tex_y_d;
      end
      // The ROM answers one cycle after tex_* update, so the id lines up with S2.
      s2_valid_q  <= s1_valid_q;
      s2_on_q     <= s1_on_q;
      s2_cid_q    <= tex_cid;
      rgb_valid_q <= s2_valid_q;
      rgb_on_q    <= s2_on_q;
      rgb_q       <= (s2_valid_q & s2_on_q) ? pal_q[s2_cid_q] : '0;
      if ((ANIM_EN != 0) && frame_tick) begin
        if (frame_cnt_q == FC_W'(ANIM_PERIOD - 1)) begin
          frame_cnt_q   <= '0;
          anim_offset_q <= anim_offset_q + 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
      if (pal_wr_valid && pal_wr_ready) pal_q[pal_wr_addr] <= pal_wr_data;
    end
  end

  assign tex_style = tex_style_q;
  assign tex_x     = tex_x_q;
  assign tex_y     = tex_y_q;
  assign rgb_valid = rgb_valid_q;
  assign rgb_on    = rgb_on_q;
  assign rgb       = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_obstacle_tile_renderer.sv
// Directed vector bench for obstacle_tile_renderer (animation period shortened to 2).
`default_nettype none

module tb_obstacle_tile_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid, obstacle_on, frame_tick;
  logic [9:0]  x_rom, y_rom;
  logic [14:0] blk_y, abs_x, abs_y;
  logic [1:0]  tex_style;
  logic [9:0]  tex_x, tex_y;
  logic [1:0]  tex_cid;
  logic        pal_wr_valid, pal_wr_ready;
  logic [1:0]  pal_wr_addr;
  logic [11:0] pal_wr_data;
  logic        rgb_valid, rgb_on;
  logic [11:0] rgb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  obstacle_tile_renderer #(.ANIM_PERIOD(2)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .pix_valid(pix_valid), .obstacle_on(obstacle_on),
    .obstacle_x_rom(x_rom), .obstacle_y_rom(y_rom), .obstacle_block_abs_y(blk_y),
    .obstacle_abs_pos_x(abs_x), .obstacle_abs_pos_y(abs_y), .frame_tick(frame_tick),
    .tex_style(tex_style), .tex_x(tex_x), .tex_y(tex_y), .tex_cid(tex_cid),
    .pal_wr_valid(pal_wr_valid), .pal_wr_ready(pal_wr_ready), .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data), .rgb_valid(rgb_valid), .rgb_on(rgb_on), .rgb(rgb)
  );

  typedef struct {
    logic [14:0] ax, ay, by;
    logic [9:0]  xr, yr;
    logic        on;
    logic [1:0]  cid;
    logic [1:0]  es;
    logic [9:0]  etx, ety;
    logic [11:0] ergb;
  } vec_t;

  vec_t tbl [8];

  function automatic vec_t mk(input logic [14:0] ax, ay, by, input logic [9:0] xr, yr,
                              input logic on, input logic [1:0] cid, input logic [1:0] es,
                              input logic [9:0] etx, ety, input logic [11:0] ergb);
    vec_t v;
    v.ax = ax; v.ay = ay; v.by = by; v.xr = xr; v.yr = yr; v.on = on; v.cid = cid;
    v.es = es; v.etx = etx; v.ety = ety; v.ergb = ergb;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_pixel(input vec_t v);
    pix_valid = 1'b1; obstacle_on = v.on; abs_x = v.ax; abs_y = v.ay; blk_y = v.by;
    x_rom = v.xr; y_rom = v.yr;
  endtask

  // One isolated pixel: tex_* after 1 edge, rgb after 3 edges.
  task automatic run_vec(input vec_t v, input string nm);
    drive_pixel(v);
    step();
    frame_tick = 1'b0;
    chk({nm, ".style"}, 32'(tex_style), 32'(v.es));
    chk({nm, ".tex_x"}, 32'(tex_x), 32'(v.etx));
    chk({nm, ".tex_y"}, 32'(tex_y), 32'(v.ety));
    pix_valid = 1'b0;
    tex_cid = v.cid;
    step();
    step();
    chk({nm, ".rgb_valid"}, 32'(rgb_valid), 32'd1);
    chk({nm, ".rgb_on"}, 32'(rgb_on), 32'(v.on));
    chk({nm, ".rgb"}, 32'(rgb), 32'(v.ergb));
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, ".rgb_valid"}, 32'(rgb_valid), 32'd0);
    chk({nm, ".rgb_on"}, 32'(rgb_on), 32'd0);
    chk({nm, ".rgb"}, 32'(rgb), 32'd0);
    chk({nm, ".tex_style"}, 32'(tex_style), 32'd0);
    chk({nm, ".tex_x"}, 32'(tex_x), 32'd0);
    chk({nm, ".tex_y"}, 32'(tex_y), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int j;
    logic [11:0] e_rgb;
    //          ax       ay       by      xr    yr    on  cid es tx   ty   rgb
    tbl[0] = mk(15'd0,   15'd0,   15'd0,  10'd0,  10'd6,  1, 2, 0, 10'd9, 10'd3,   12'h000);
    tbl[1] = mk(15'd0,   15'd1,   15'd0,  10'd13, 10'd0,  1, 3, 1, 10'd3, 10'd0,   12'h5B0);
    tbl[2] = mk(15'd0,   15'd3,   15'd0,  10'd0,  10'd2,  1, 1, 3, 10'd9, 10'd1,   12'h777);
    tbl[3] = mk(15'd6,   15'd0,   15'd1,  10'd0,  10'd5,  1, 0, 1, 10'd0, 10'd2,   12'hAAA);
    tbl[4] = mk(15'd0,   15'd2,   15'd0,  10'd7,  10'd9,  0, 1, 2, 10'd7, 10'd4,   12'h000);
    tbl[5] = mk(15'd0,   15'd5,   15'd0,  10'd19, 10'd1023, 1, 3, 0, 10'd0, 10'd511, 12'h5B0);
    tbl[6] = mk(15'd0,   15'd1,   15'd0,  10'd9,  10'd0,  1, 0, 1, 10'd9, 10'd0,   12'hAAA);
    tbl[7] = mk(15'h7FFF, 15'd0,  15'h1D, 10'd0,  10'd0,  1, 2, 1, 10'd0, 10'd0,   12'h000);

    rst_n = 1'b0; pix_valid = 1'b0; obstacle_on = 1'b0; frame_tick = 1'b0;
    x_rom = '0; y_rom = '0; blk_y = '0; abs_x = '0; abs_y = '0; tex_cid = '0;
    pal_wr_valid = 1'b0; pal_wr_addr = '0; pal_wr_data = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk_idle_outputs("reset");
    chk("reset.wr_ready", 32'(pal_wr_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Animation: offset reaches 1 after 2 ticks; the 4th tick coincides with a pixel.
    frame_tick = 1'b1;
    step(); step(); step();
    run_vec(mk(15'd0, 15'd3, 15'd0, 10'd0, 10'd0, 1, 0, 0, 10'd9, 10'd0, 12'hAAA), "anim_tick_same");
    run_vec(mk(15'd0, 15'd3, 15'd0, 10'd0, 10'd0, 1, 0, 1, 10'd9, 10'd0, 12'hAAA), "anim_off2");
    frame_tick = 1'b1;
    step(); step(); step(); step();
    frame_tick = 1'b0;
    run_vec(mk(15'd0, 15'd3, 15'd0, 10'd0, 10'd0, 1, 0, 3, 10'd9, 10'd0, 12'hAAA), "anim_wrap");

    // Streaming with a palette write held pending until the pipeline drains.
    pal_wr_valid = 1'b1; pal_wr_addr = 2'd2; pal_wr_data = 12'hFFF;
    abs_x = '0; abs_y = '0; blk_y = '0; x_rom = '0; y_rom = '0;
    for (int k = 0; k <= 66; k++) begin
      if (k < 64) begin
        pix_valid = 1'b1;
        obstacle_on = (k % 2 == 1);
      end else begin
        pix_valid = 1'b0;
        obstacle_on = 1'b0;
      end
      if (k >= 1 && k <= 64) tex_cid = ((k - 1) % 4 == 3) ? 2'd2 : 2'd1;
      #1;
      chk("stream.wr_ready_low", 32'(pal_wr_ready), 32'd0);
      step();
      j = k - 2;
      if (j >= 0 && j < 64) begin
        if (j % 2 == 1) e_rgb = (j % 4 == 3) ? 12'h000 : 12'h777;
        else e_rgb = 12'h000;
        chk($sformatf("stream%0d.valid", j), 32'(rgb_valid), 32'd1);
        chk($sformatf("stream%0d.on", j), 32'(rgb_on), 32'(j % 2));
        chk($sformatf("stream%0d.rgb", j), 32'(rgb), 32'(e_rgb));
      end else if (j == 64) begin
        chk("stream.drained", 32'(rgb_valid), 32'd0);
      end
    end
    n = 0;
    while (n < 10 && !pal_wr_ready) begin
      step();
      n++;
    end
    chk("wr_ready_idle", 32'(pal_wr_ready), 32'd1);
    step();
    pal_wr_valid = 1'b0;
    run_vec(mk(15'd0, 15'd0, 15'd0, 10'd0, 10'd6, 1, 2, 0, 10'd9, 10'd3, 12'hFFF), "pal_written");

    // Reset with three pixels in flight.
    tex_cid = 2'd1;
    for (int k = 0; k < 3; k++) begin
      drive_pixel(mk(15'd0, 15'd1, 15'd0, 10'd13, 10'd8, 1, 1, 0, 10'd0, 10'd0, 12'h0));
      step();
    end
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("postreset%0d.valid", k), 32'(rgb_valid), 32'd0);
    end
    run_vec(mk(15'd0, 15'd0, 15'd0, 10'd0, 10'd6, 1, 2, 0, 10'd9, 10'd3, 12'h000), "pal_reloaded");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
